// File: rtl/keccak_msg_feeder.sv
// Input-side streamer for the Keccak core.
// Takes byte-packed 32-bit message words over valid/ready, applies FIPS-202
// multi-rate padding for the selected mode, and hands rate-sized blocks of
// words to the core through a single registered output slot.
//
// Handshakes: an upstream word moves when msg_valid && msg_ready; a slot word
// moves to the core when wr_en && core_ready. A producer never withdraws a
// word while its valid is high, and slot contents are frozen until accepted.
module keccak_msg_feeder #(
  parameter logic [7:0] SHA3_DS  = 8'h06,
  parameter logic [7:0] SHAKE_DS = 8'h1F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  cmode,
  input  logic        start,
  input  logic [31:0] msg_data,
  input  logic [2:0]  msg_nbytes,
  input  logic        msg_valid,
  input  logic        msg_last,
  output logic        msg_ready,
  output logic [31:0] dt_i_hash,
  output logic        wr_en,
  input  logic        core_ready,
  output logic        block_last,
  output logic        msg_end,
  output logic        busy,
  output logic        done,
  output logic        mode_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_PAD  = 3'd2,
    S_PADZ = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t      state;
  state_t      nxt_state;
  logic [5:0]  wcnt;       // block position of the next word loaded into the slot
  logic [5:0]  last_idx;   // rate in words minus one, latched on start
  logic [7:0]  ds;         // domain/pad-start byte, latched on start

  logic        slot_free;
  logic        at_last;
  logic        accept;
  logic        mode_ok;
  logic        load_en;
  logic        load_final;
  logic [31:0] load_word;
  logic [31:0] pad_word;
  logic [31:0] pad_start;
  logic [31:0] zero_word;
  logic [7:0]  top_pad;

  // Last word index of a block for each supported mode (rate / 4 - 1)
  function automatic logic [5:0] rate_last(input logic [2:0] m);
    case (m)
      3'd0:    rate_last = 6'd35;
      3'd1:    rate_last = 6'd33;
      3'd2:    rate_last = 6'd25;
      3'd3:    rate_last = 6'd17;
      3'd4:    rate_last = 6'd41;
      3'd5:    rate_last = 6'd33;
      default: rate_last = 6'd0;
    endcase
  endfunction

  assign slot_free = !wr_en || core_ready;
  assign at_last   = (wcnt == last_idx);
  assign msg_ready = (state == S_DATA) && slot_free;
  assign accept    = msg_valid && msg_ready;
  assign mode_ok   = (cmode <= 3'd5);
  assign top_pad   = at_last ? 8'h80 : 8'h00;
  assign pad_start = {top_pad, 16'h0000, ds};
  assign zero_word = {top_pad, 24'h000000};

  // Partial last word: keep bytes below n, place DS at byte n, zero the rest
  always_comb begin
    pad_word = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(msg_nbytes))
        pad_word[i*8 +: 8] = msg_data[i*8 +: 8];
      else if (i == int'(msg_nbytes))
        pad_word[i*8 +: 8] = ds;
    end
    pad_word[31:24] = pad_word[31:24] | top_pad;
  end

  // Decide what goes into the output slot this cycle and where the FSM goes
  always_comb begin
    load_en    = 1'b0;
    load_final = 1'b0;
    load_word  = 32'h0;
    nxt_state  = state;
    case (state)
      S_IDLE: begin
        if (start && mode_ok) nxt_state = S_DATA;
      end
      S_DATA: begin
        if (accept) begin
          load_en = 1'b1;
          if (!msg_last) begin
            load_word = msg_data;
          end else if (msg_nbytes >= 3'd4) begin
            load_word = msg_data;
            nxt_state = S_PAD;
          end else begin
            load_word  = pad_word;
            load_final = at_last;
            nxt_state  = at_last ? S_FIN : S_PADZ;
          end
        end
      end
      S_PAD: begin
        if (slot_free) begin
          load_en    = 1'b1;
          load_word  = pad_start;
          load_final = at_last;
          nxt_state  = at_last ? S_FIN : S_PADZ;
        end
      end
      S_PADZ: begin
        if (slot_free) begin
          load_en    = 1'b1;
          load_word  = zero_word;
          load_final = at_last;
          if (at_last) nxt_state = S_FIN;
        end
      end
      S_FIN: begin
        if (wr_en && core_ready) nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // State, mode latches, output slot and status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wcnt       <= 6'd0;
      last_idx   <= 6'd0;
      ds         <= 8'h00;
      dt_i_hash  <= 32'h0;
      wr_en      <= 1'b0;
      block_last <= 1'b0;
      msg_end    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mode_err   <= 1'b0;
    end else begin
      state    <= nxt_state;
      done     <= 1'b0;
      mode_err <= 1'b0;
      if (wr_en && core_ready) wr_en <= 1'b0;
      if (state == S_IDLE && start) begin
        if (mode_ok) begin
          last_idx <= rate_last(cmode);
          ds       <= (cmode >= 3'd4) ? SHAKE_DS : SHA3_DS;
          wcnt     <= 6'd0;
          busy     <= 1'b1;
        end else begin
          mode_err <= 1'b1;
        end
      end
      if (load_en) begin
        dt_i_hash  <= load_word;
        wr_en      <= 1'b1;
        block_last <= at_last;
        msg_end    <= load_final;
        wcnt       <= at_last ? 6'd0 : wcnt + 6'd1;
      end
      if (state == S_FIN && wr_en && core_ready) begin
        done       <= 1'b1;
        busy       <= 1'b0;
        dt_i_hash  <= 32'h0;
        block_last <= 1'b0;
        msg_end    <= 1'b0;
        wcnt       <= 6'd0;
      end
    end
  end

endmodule

// File: tb/tb_keccak_msg_feeder.sv
// Bench for keccak_msg_feeder: directed messages, expected word stream held
// in a queue, monitor pops on every core handshake.
module tb_keccak_msg_feeder;

  logic        clk;
  logic        rst_n;
  logic [2:0]  cmode;
  logic        start;
  logic [31:0] msg_data;
  logic [2:0]  msg_nbytes;
  logic        msg_valid;
  logic        msg_last;
  logic        msg_ready;
  logic [31:0] dt_i_hash;
  logic        wr_en;
  logic        core_ready;
  logic        block_last;
  logic        msg_end;
  logic        busy;
  logic        done;
  logic        mode_err;

  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];   // {word, block_last, msg_end}
  logic        done_pend = 1'b0;

  keccak_msg_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmode      (cmode),
    .start      (start),
    .msg_data   (msg_data),
    .msg_nbytes (msg_nbytes),
    .msg_valid  (msg_valid),
    .msg_last   (msg_last),
    .msg_ready  (msg_ready),
    .dt_i_hash  (dt_i_hash),
    .wr_en      (wr_en),
    .core_ready (core_ready),
    .block_last (block_last),
    .msg_end    (msg_end),
    .busy       (busy),
    .done       (done),
    .mode_err   (mode_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] d, input logic bl, input logic me);
    exp_q.push_back({d, bl, me});
  endtask

  task automatic exp_zeros(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({32'h0, 1'b0, 1'b0});
  endtask

  // driver tasks
  task automatic start_msg(input logic [2:0] m);
    @(posedge clk); #1;
    cmode = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] n);
    int t;
    msg_data   = d;
    msg_last   = last;
    msg_nbytes = n;
    msg_valid  = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (msg_ready) break;
      t++;
      if (t >= 200) begin
        checks++;
        errors++;
        $display("FAIL send_word timeout: got ready=0 expected ready=1");
        break;
      end
    end
    @(posedge clk); #1;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy || done_pend) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    checks++;
    if (t >= 2000) begin
      errors++;
      $display("FAIL %s timeout: got %0d words left expected 0", name, exp_q.size());
    end
  endtask

  // scoreboard monitor: compare each word the core accepts
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_pend) begin
        chk("done_pulse", {63'h0, done}, 64'h1);
        chk("busy_after_done", {63'h0, busy}, 64'h0);
        done_pend = 1'b0;
      end else if (done) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got 1 expected 0");
      end
      if (wr_en && core_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected none", dt_i_hash);
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          chk("out_word", {30'h0, dt_i_hash, block_last, msg_end}, {30'h0, e});
          if (msg_end) done_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [31:0] held_d;

    rst_n      = 1'b0;
    cmode      = 3'd0;
    start      = 1'b0;
    msg_data   = 32'h0;
    msg_nbytes = 3'd0;
    msg_valid  = 1'b0;
    msg_last   = 1'b0;
    core_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dt", {32'h0, dt_i_hash}, 64'h0);
    chk("rst_flags", {57'h0, wr_en, msg_ready, block_last, msg_end, busy, done, mode_err}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // SHA3-256 empty message
    start_msg(3'd1);
    exp_push(32'h00000006, 1'b0, 1'b0);
    exp_zeros(32);
    exp_push(32'h80000000, 1'b1, 1'b1);
    send_word(32'h0, 1'b1, 3'd0);
    wait_done("empty");

    // SHA3-256 "abc"
    start_msg(3'd1);
    exp_push(32'h06636261, 1'b0, 1'b0);
    exp_zeros(32);
    exp_push(32'h80000000, 1'b1, 1'b1);
    send_word(32'h00636261, 1'b1, 3'd3);
    wait_done("abc");

    // SHA3-256 136 bytes: one full block then a full padding block
    start_msg(3'd1);
    for (int i = 0; i < 34; i++) exp_push(32'hA0000000 + i, (i == 33), 1'b0);
    exp_push(32'h00000006, 1'b0, 1'b0);
    exp_zeros(32);
    exp_push(32'h80000000, 1'b1, 1'b1);
    for (int i = 0; i < 34; i++) send_word(32'hA0000000 + i, (i == 33), (i == 33) ? 3'd4 : 3'd0);
    wait_done("sha3_256_136");

    // SHA3-512 71 bytes: DS and 0x80 share the last word of the block
    start_msg(3'd3);
    for (int i = 0; i < 17; i++) exp_push(32'hB0000000 + i, 1'b0, 1'b0);
    exp_push(32'h86CCBBAA, 1'b1, 1'b1);
    for (int i = 0; i < 17; i++) send_word(32'hB0000000 + i, 1'b0, 3'd0);
    send_word(32'h00CCBBAA, 1'b1, 3'd3);
    wait_done("sha3_512_71");

    // SHAKE128 one full word with a 5-cycle core stall mid-stream
    start_msg(3'd4);
    exp_push(32'h11223344, 1'b0, 1'b0);
    exp_push(32'h0000001F, 1'b0, 1'b0);
    exp_zeros(39);
    exp_push(32'h80000000, 1'b1, 1'b1);
    send_word(32'h11223344, 1'b1, 3'd4);
    repeat (3) @(posedge clk);
    #1;
    core_ready = 1'b0;
    msg_valid  = 1'b1;
    msg_data   = 32'hDEADBEEF;
    @(negedge clk);
    held_d = dt_i_hash;
    chk("stall_wr_en", {63'h0, wr_en}, 64'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_data", {32'h0, dt_i_hash}, {32'h0, held_d});
      chk("stall_ready", {62'h0, wr_en, msg_ready}, 64'h2);
    end
    @(posedge clk); #1;
    core_ready = 1'b1;
    msg_valid  = 1'b0;
    wait_done("shake128_stall");

    // SHA3-384 reset mid-block, then "abc"
    start_msg(3'd2);
    for (int i = 0; i < 5; i++) exp_push(32'hC0000000 + i, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_word(32'hC0000000 + i, 1'b0, 3'd0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_dt", {32'h0, dt_i_hash}, 64'h0);
    chk("midrst_flags", {57'h0, wr_en, msg_ready, block_last, msg_end, busy, done, mode_err}, 64'h0);
    chk("midrst_queue", 64'(exp_q.size()), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_msg(3'd2);
    exp_push(32'h06636261, 1'b0, 1'b0);
    exp_zeros(24);
    exp_push(32'h80000000, 1'b1, 1'b1);
    send_word(32'h00636261, 1'b1, 3'd3);
    wait_done("sha3_384_after_reset");

    // unsupported mode
    @(posedge clk); #1;
    cmode = 3'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("mode_err_pulse", {62'h0, mode_err, busy}, 64'h2);
    @(negedge clk);
    chk("mode_err_clear", {61'h0, mode_err, busy, msg_ready}, 64'h0);

    repeat (2) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keccak_msg_feeder.md
Name: keccak_msg_feeder

Overview:
- Synthesizable input-side streamer for the Keccak core.
- Accepts the byte-packed message as 32-bit words from an upstream source (memory reader or test source) using a valid/ready handshake.
- Applies FIPS-202 multi-rate padding for the selected cmode and delivers rate-sized blocks of 32-bit words to the core.
- Marks the last word of each block and the end of the message. This is the counterpart of the core's hash-output path.

Parameters:
- SHA3_DS, 8'h06: domain/pad-start byte for cmode 0-3 (SHA3-224/256/384/512).
- SHAKE_DS, 8'h1F: domain/pad-start byte for cmode 4-5 (SHAKE128/256).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- cmode  in  3  mode; sampled only on an accepted start.
- start  in  1  one-cycle message start request.
- msg_data  in  32  message word; byte0 = bits[7:0] is the earliest byte.
- msg_nbytes  in  3  valid bytes in the last word, 0..4; used only with msg_last.
- msg_valid  in  1  upstream word valid.
- msg_last  in  1  current word is the final message word.
- msg_ready  out  1  feeder accepts the upstream word this cycle.
- dt_i_hash  out  32  word to the core.
- wr_en  out  1  dt_i_hash valid.
- core_ready  in  1  core accepts dt_i_hash this cycle.
- block_last  out  1  dt_i_hash is the last word of a rate block.
- msg_end  out  1  dt_i_hash belongs to the final block; asserted only together with block_last.
- busy  out  1  message in progress.
- done  out  1  one-cycle pulse after the final word is accepted.
- mode_err  out  1  one-cycle pulse when start arrives with cmode 6/7.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, word counter 0, all outputs 0, including msg_ready and dt_i_hash. Reset mid-message discards the message; nothing is flushed.
- Rate in words is latched on start: cmode 0→36, 1→34, 2→26, 3→18, 4→42, 5→34. DS is SHA3_DS for cmode 0-3, SHAKE_DS for 4-5.
- cmode 6/7 with start in IDLE: mode_err pulses the next cycle; the block stays in IDLE.
- start while busy is ignored.
- Output stage is a single register slot holding dt_i_hash, wr_en, block_last and msg_end. Contents stay stable while wr_en=1 and core_ready=0. The slot advances only on wr_en && core_ready.
- The word counter increments on each core handshake and wraps to 0 after rate-1. block_last = (counter == rate-1).
- States:
  - IDLE: busy=0. An accepted start sets busy=1 the next cycle and goes to DATA.
  - DATA: msg_ready = msg_valid-independent (!wr_en || core_ready). An upstream transfer occurs on msg_valid && msg_ready; latency is 1 cycle to wr_en.
    - Word without msg_last: passed unmodified.
    - msg_last with nbytes n<4: bytes ≥n are zeroed, byte n = DS, go to PADZ. If that word is the last of its block, byte3 |= 0x80 and go to FIN instead.
    - msg_last with n=4: word passed unmodified, go to PAD.
    - msg_last with n=0: empty word. Byte0 = DS, rest 0, same rules as n<4.
  - PAD: msg_ready=0. Emit DS in byte0, rest 0 (byte3 |= 0x80 if last of block, then FIN; otherwise PADZ).
  - PADZ: msg_ready=0. Emit 0x00000000 words until the last word of the block, which is 0x80000000; that word goes to FIN.
  - FIN: the final emitted word carries block_last=1 and msg_end=1. When it is accepted, done pulses one cycle, busy drops, state returns to IDLE.
- Padding always completes the current block. A message ending exactly on a block boundary produces one full extra padding block.
- msg_end is never asserted on a non-final block.
- msg_valid while not in DATA: no transfer occurs (msg_ready=0).

Test Plan:
- SHA3-256, empty message (msg_last, nbytes=0) → 34 words: word0=0x00000006, words1-32=0, word33=0x80000000 with block_last=msg_end=1; done one cycle after acceptance.
- SHA3-256 "abc" (0x00636261, nbytes=3) → word0=0x06636261, words1-32=0, word33=0x80000000 with msg_end.
- SHA3-256, 136-byte message (34 full words, last nbytes=4):
  - block 1 passes through unchanged; block_last at word 33 with msg_end=0.
  - block 2: word0=0x00000006, word33=0x80000000 with msg_end.
- SHA3-512, 71 bytes (17 full words + last 0x00CCBBAA, nbytes=3) → word17=0x86CCBBAA with block_last=msg_end=1, no extra block.
- SHAKE128, one word with nbytes=4 and core_ready held low 5 cycles mid-stream:
  - dt_i_hash/wr_en stay stable and msg_ready=0 during the stall.
  - word1=0x0000001F, word41=0x80000000 with msg_end.
- Reset mid-block in SHA3-384, then restart with "abc" → all outputs 0 after reset; the new message has the first block_last at word 25.
- start with cmode=7 → mode_err pulses, busy stays 0.
